// File: rtl/cpu_pkg.sv
// Shared definitions for the decode/execute core and its ALU:
// opcode constants, instruction field widths and the sequencer state encoding.
package cpu_pkg;

  localparam int OPC_W  = 4;
  localparam int RIDX_W = 2;
  localparam int DATA_W = 4;
  localparam int PC_W   = 8;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
  localparam logic [OPC_W-1:0] OP_INC  = 4'h5;
  localparam logic [OPC_W-1:0] OP_NOT  = 4'h6;
  localparam logic [OPC_W-1:0] OP_LSL  = 4'h7;
  localparam logic [OPC_W-1:0] OP_LSR  = 4'h8;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h9;
  localparam logic [OPC_W-1:0] OP_BZ   = 4'hA;
  localparam logic [OPC_W-1:0] OP_BN   = 4'hB;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'hC;
  localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_OPERAND = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_e;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_LSR);
  endfunction

  function automatic logic is_branch_op(input logic [OPC_W-1:0] op);
    return (op == OP_BZ) || (op == OP_BN) || (op == OP_JMP);
  endfunction

endpackage

// File: rtl/regfile4x4.sv
// Four 4-bit registers: two combinational read ports, one synchronous write port.
// Read data follows the address in the same cycle; asynchronous active-low clear.
module regfile4x4
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [RIDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RIDX_W-1:0] raddr_a_i,
  input  logic [RIDX_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [4];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/decode_exec.sv
// Byte-serial fetch/decode/execute sequencer driving an external registered ALU.
// ALU ops retire 2 clocks after the fetch-ack edge; fetches stall on imem_ack.
// DECODE_EXEC_BRANCH_EN enables BZ/BN/JMP; otherwise those opcodes are 1-byte NOPs.
module decode_exec
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic [3:0] alu_op,
  output logic [3:0] alu_rx,
  output logic [3:0] alu_ry,
  input  logic [3:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_n,
  output logic       flag_z,
  output logic       flag_n,
  output logic       halted
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;

  logic [OPC_W-1:0]  fetch_opc;
  logic [OPC_W-1:0]  ir_opc;
  logic [RIDX_W-1:0] ir_rd;
  logic [RIDX_W-1:0] ir_rs;
  logic              exec_active;

  assign fetch_opc = imem_data[7:4];
  assign ir_opc    = ir_q[7:4];
  assign ir_rd     = ir_q[3:2];
  assign ir_rs     = ir_q[1:0];

  regfile4x4 u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .we_i      (rf_we),
    .waddr_i   (ir_rd),
    .wdata_i   (rf_wdata),
    .raddr_a_i (ir_rd),
    .raddr_b_i (ir_rs),
    .rdata_a_o (rf_rdata_a),
    .rdata_b_o (rf_rdata_b)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    rf_we    = 1'b0;
    rf_wdata = alu_out;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        if (imem_ack) begin
          ir_d = imem_data;
          pc_d = pc_q + 8'd1;
          if (is_alu_op(fetch_opc)) begin
            state_d = ST_EXEC;
`ifdef DECODE_EXEC_BRANCH_EN
          end else if ((fetch_opc == OP_LDI) || is_branch_op(fetch_opc)) begin
`else
          end else if (fetch_opc == OP_LDI) begin
`endif
            state_d = ST_OPERAND;
          end else if (fetch_opc == OP_HALT) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_OPERAND: begin
        if (imem_ack) begin
          pc_d    = pc_q + 8'd1;
          state_d = ST_FETCH;
          if (ir_opc == OP_LDI) begin
            rf_we    = 1'b1;
            rf_wdata = imem_data[DATA_W-1:0];
          end
`ifdef DECODE_EXEC_BRANCH_EN
          // Untaken conditional branches fall through past their operand byte.
          if ((ir_opc == OP_JMP) ||
              ((ir_opc == OP_BZ) && flag_z_q) ||
              ((ir_opc == OP_BN) && flag_n_q)) begin
            pc_d = imem_data;
          end
`endif
        end
      end

      ST_EXEC: state_d = ST_WB;

      ST_WB: begin
        rf_we    = 1'b1;
        flag_z_d = alu_z;
        flag_n_d = alu_n;
        state_d  = ST_FETCH;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= '0;
      ir_q     <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  assign exec_active = (state_q == ST_EXEC);

  assign imem_addr = pc_q;
  assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_OPERAND);
  assign halted    = (state_q == ST_HALT);
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign alu_op    = exec_active ? ir_opc     : '0;
  assign alu_rx    = exec_active ? rf_rdata_a : '0;
  assign alu_ry    = exec_active ? rf_rdata_b : '0;

endmodule

// File: doc/decode_exec.md
DECODE_EXEC -- requirements
Module: decode_exec

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: imem_addr  out  8  instruction-memory byte address (PC).
REQ-004 SHALL have ports: imem_req  out  1  fetch request.
REQ-005 SHALL have ports: imem_ack  in  1  fetch acknowledge; imem_data valid while high.
REQ-006 SHALL have ports: imem_data  in  8  fetched byte.
REQ-007 SHALL have ports: alu_op  out  4  operation to ALU (0001 add, 0010 sub, 0011 and, 0100 or, 0101 inc, 0110 not, 0111 lsl, 1000 lsr, 0000 pass rx).
REQ-008 SHALL have ports: alu_rx, alu_ry  out  4 each  ALU operands.
REQ-009 SHALL have ports: alu_out  in  4  ALU result, registered by ALU on clk.
REQ-010 SHALL have ports: alu_z, alu_n  in  1 each  ALU zero / negative of alu_out.
REQ-011 SHALL have ports: flag_z, flag_n  out  1 each  architectural flags; halted  out  1  core stopped.

Function
REQ-012 SHALL decode instruction byte: [7:4] opcode, [3:2] rd (also rx), [1:0] rs (ry); four 4-bit registers r0..r3.
REQ-013 SHALL use states BOOT, FETCH, OPERAND, EXEC, WB, HALT; imem_req = 1 exactly in FETCH and OPERAND.
REQ-014 SHALL hold imem_addr stable while imem_req is high; on clock with imem_ack high, capture imem_data, PC <= PC+1 mod 256 (0xFF wraps to 0x00).
REQ-015 SHALL transition BOOT -> FETCH unconditionally after one clock.
REQ-016 SHALL, in FETCH on ack: opcodes 0001-1000 -> EXEC; 1001 (LDI), 1010 (BZ), 1011 (BN), 1100 (JMP) -> OPERAND; 1111 -> HALT; 0000, 1101, 1110 -> FETCH (NOP, no register or flag change).
REQ-017 SHALL, in OPERAND on ack: LDI writes imem_data[3:0] to rd; JMP sets PC <= imem_data; BZ/BN set PC <= imem_data only if flag_z/flag_n is 1, else keep incremented PC; flags unchanged; -> FETCH.
REQ-018 SHALL drive alu_op=opcode, alu_rx=r[rd], alu_ry=r[rs] only in EXEC; outside EXEC alu_op=0000, alu_rx=0, alu_ry=0.
REQ-019 SHALL go EXEC -> WB after one clock; in WB write alu_out to rd, flag_z<=alu_z, flag_n<=alu_n, -> FETCH. ALU instruction latency: fetch-ack edge + 2 clocks.
REQ-020 SHALL treat rd==rs as legal (both operands same register, result overwrites it).
REQ-021 SHALL remain in HALT with halted=1 and imem_req=0 until reset.

Reset
REQ-022 SHALL on rst_n low, immediately and regardless of state: state=BOOT, PC=0x00, r0..r3=0, flag_z=0, flag_n=0, halted=0, imem_req=0, alu_op=0000, alu_rx=alu_ry=0.
REQ-023 SHALL discard any in-flight fetch or writeback on reset; an imem_ack during reset is ignored.

Configuration
REQ-024 SHALL, with DECODE_EXEC_BRANCH_EN defined, implement BZ/BN/JMP per REQ-017.
REQ-025 SHALL, without DECODE_EXEC_BRANCH_EN, treat 1010/1011/1100 as single-byte NOP (FETCH -> FETCH, no operand fetch, PC+1 only).

Structure
REQ-026 SHALL place opcode constants, state encoding typedef and instruction field widths in shared package cpu_pkg, also used by ALU.
REQ-027 SHALL instantiate sub-module regfile4x4 (4x4 bits, two combinational read ports, one synchronous write port, async active-low clear).

Verification
REQ-028 SHALL: program LDI r0,5; LDI r1,3; ADD r0,r1 with ack same cycle as req -> r0=8, flag_z=0, flag_n=1, PC=0x05.
REQ-029 SHALL: SUB r0,r0 with r0=8 -> r0=0, flag_z=1, flag_n=0; following BZ 0x20 -> imem_addr=0x20 next fetch.
REQ-030 SHALL: BN 0x40 with flag_n=0 -> no jump, next imem_addr = branch address+2; without DECODE_EXEC_BRANCH_EN -> next imem_addr = branch address+1.
REQ-031 SHALL: imem_ack delayed 3 clocks -> imem_addr and imem_req held stable all 3 cycles, single PC increment.
REQ-032 SHALL: JMP 0x00 at address 0xFE (operand at 0xFF) -> PC wraps to 0x00; byte 0xF0 -> halted=1, imem_req=0 for 10+ clocks.
REQ-033 SHALL: rst_n pulsed low in WB of ADD -> rd not written, all outputs at reset values, first fetch at 0x00 two clocks after release.
